// File: rtl/core_test_pkg.sv
// Shared types and constants for the core self-test sequencer.
package core_test_pkg;

  localparam int NUM_PAT = 16;
  localparam int PAT_W   = 24;

  localparam int ERR_DA = 0;
  localparam int ERR_AA = 1;
  localparam int ERR_DB = 2;
  localparam int ERR_AB = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GO,
    ST_WAIT_BUSY,
    ST_WAIT_END,
    ST_NEXT,
    ST_DONE
  } seq_state_t;

  // Maps (port, error kind) onto the sticky status bit position.
  function automatic int err_index(input logic port_b, input logic addr_err);
    if (port_b) return addr_err ? ERR_AB : ERR_DB;
    else        return addr_err ? ERR_AA : ERR_DA;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for a core handshake line, plus a rising-edge pulse.
module sync_edge_det (
  input  logic clk_50m,
  input  logic rst_core_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta_reg;
  logic sync_reg;
  logic dly_reg;

  always_ff @(posedge clk_50m or negedge rst_core_n) begin
    if (!rst_core_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      dly_reg  <= 1'b0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      dly_reg  <= sync_reg;
    end
  end

  assign level = sync_reg;
  assign rise  = sync_reg & ~dly_reg;

endmodule

// File: rtl/core_test_seq.sv
// Core self-test sequencer: loads the pattern set, launches each enabled port
// and collects the per-port error flags with a bounded wait for completion.
module core_test_seq
  import core_test_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                     clk_50m,
  input  logic                     rst_core_n,
  input  logic                     test_start,
  input  logic                     test_abort,
  input  logic [1:0]               port_mask,
  input  logic [NUM_PAT*PAT_W-1:0] pattern_bus,
  output logic                     seq_core_pat_vld,
  output logic [3:0]               seq_core_pat_idx,
  output logic [PAT_W-1:0]         seq_core_pat_data,
  input  logic                     core_seq_pat_rdy,
  output logic                     seq_core_port_sel,
  output logic                     seq_core_go,
  input  logic                     core_seq_busy,
  input  logic                     core_seq_end,
  input  logic                     core_seq_a_err,
  input  logic                     core_seq_d_err,
  output logic                     seq_busy,
  output logic                     seq_done,
  output logic [3:0]               seq_err_status,
  output logic                     seq_timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       IDX_LAST = 4'(NUM_PAT - 1);

  // Bit order of the conditioned core inputs: {d_err, a_err, end, busy}.
  logic [3:0] raw_in;
  logic [3:0] lvl;
  logic [3:0] rise;
  logic       unused_lvl;

  assign raw_in     = {core_seq_d_err, core_seq_a_err, core_seq_end, core_seq_busy};
  assign unused_lvl = ^lvl[3:1];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      sync_edge_det u_sync (
        .clk_50m    (clk_50m),
        .rst_core_n (rst_core_n),
        .din        (raw_in[gi]),
        .level      (lvl[gi]),
        .rise       (rise[gi])
      );
    end
  endgenerate

  logic busy_lvl, busy_rise, end_rise, a_rise, d_rise;
  assign busy_lvl  = lvl[0];
  assign busy_rise = rise[0];
  assign end_rise  = rise[1];
  assign a_rise    = rise[2];
  assign d_rise    = rise[3];

  seq_state_t       state_reg;
  logic             run_b_reg;
  logic             pat_vld_reg;
  logic [3:0]       pat_idx_reg;
  logic [PAT_W-1:0] pat_data_reg;
  logic             port_sel_reg;
  logic             go_reg;
  logic             done_reg;
  logic [3:0]       err_reg;
  logic             timeout_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [CNT_W-1:0] cnt_next;
  logic [3:0]       idx_next;
  logic             in_wait;
  logic             tmo_hit;

  assign cnt_next = cnt_reg + 1'b1;
  assign idx_next = pat_idx_reg + 1'b1;
  assign in_wait  = (state_reg == ST_WAIT_BUSY) || (state_reg == ST_WAIT_END);
  assign tmo_hit  = (cnt_next == CNT_LAST);

  always_ff @(posedge clk_50m or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_reg    <= ST_IDLE;
      run_b_reg    <= 1'b0;
      pat_vld_reg  <= 1'b0;
      pat_idx_reg  <= '0;
      pat_data_reg <= '0;
      port_sel_reg <= 1'b0;
      go_reg       <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= '0;
      timeout_reg  <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      go_reg   <= 1'b0;
      done_reg <= 1'b0;

      if (in_wait) begin
        cnt_reg <= cnt_next;
        if (a_rise) err_reg[err_index(port_sel_reg, 1'b1)] <= 1'b1;
        if (d_rise) err_reg[err_index(port_sel_reg, 1'b0)] <= 1'b1;
      end

      // DONE is already on its way out, so an abort there adds nothing.
      if (test_abort && state_reg != ST_IDLE && state_reg != ST_DONE) begin
        state_reg   <= ST_DONE;
        pat_vld_reg <= 1'b0;
        done_reg    <= 1'b1;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (test_start) begin
              if (port_mask != 2'b00) begin
                run_b_reg    <= port_mask[1];
                port_sel_reg <= ~port_mask[0];
                err_reg      <= '0;
                timeout_reg  <= 1'b0;
                cnt_reg      <= '0;
                pat_vld_reg  <= 1'b1;
                pat_idx_reg  <= '0;
                pat_data_reg <= pattern_bus[0 +: PAT_W];
                state_reg    <= ST_LOAD;
              end else begin
                done_reg <= 1'b1;
              end
            end
          end

          ST_LOAD: begin
            if (core_seq_pat_rdy) begin
              if (pat_idx_reg == IDX_LAST) begin
                pat_vld_reg <= 1'b0;
                pat_idx_reg <= '0;
                go_reg      <= 1'b1;
                state_reg   <= ST_GO;
              end else begin
                pat_idx_reg  <= idx_next;
                pat_data_reg <= pattern_bus[int'(idx_next)*PAT_W +: PAT_W];
              end
            end
          end

          ST_GO: begin
            cnt_reg   <= '0;
            state_reg <= ST_WAIT_BUSY;
          end

          ST_WAIT_BUSY: begin
            if (tmo_hit) begin
              timeout_reg <= 1'b1;
              done_reg    <= 1'b1;
              state_reg   <= ST_DONE;
            end else if (end_rise) begin
              state_reg <= ST_NEXT;
            end else if (busy_rise) begin
              state_reg <= ST_WAIT_END;
            end
          end

          ST_WAIT_END: begin
            if (tmo_hit) begin
              timeout_reg <= 1'b1;
              done_reg    <= 1'b1;
              state_reg   <= ST_DONE;
            end else if (end_rise && !busy_lvl) begin
              state_reg <= ST_NEXT;
            end
          end

          ST_NEXT: begin
            if (!port_sel_reg && run_b_reg) begin
              port_sel_reg <= 1'b1;
              pat_vld_reg  <= 1'b1;
              pat_idx_reg  <= '0;
              pat_data_reg <= pattern_bus[0 +: PAT_W];
              state_reg    <= ST_LOAD;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end
          end

          ST_DONE: state_reg <= ST_IDLE;

          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign seq_core_pat_vld  = pat_vld_reg;
  assign seq_core_pat_idx  = pat_idx_reg;
  assign seq_core_pat_data = pat_data_reg;
  assign seq_core_port_sel = port_sel_reg;
  assign seq_core_go       = go_reg;
  assign seq_done          = done_reg;
  assign seq_err_status    = err_reg;
  assign seq_timeout       = timeout_reg;
  assign seq_busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_core_test_seq.sv
// Bench for core_test_seq: behavioural core responder plus an expected-transfer model.
module tb_core_test_seq;
  import core_test_pkg::*;

  localparam int TMO      = 100;
  localparam int BUSY_DLY = 5;
  localparam int END_DLY  = 20;

  logic                     clk_50m = 1'b0;
  logic                     rst_core_n = 1'b1;
  logic                     test_start = 1'b0;
  logic                     test_abort = 1'b0;
  logic [1:0]               port_mask = 2'b00;
  logic [NUM_PAT*PAT_W-1:0] pattern_bus = '0;
  logic                     core_seq_pat_rdy = 1'b0;
  logic                     core_seq_busy = 1'b0;
  logic                     core_seq_end = 1'b0;
  logic                     core_seq_a_err = 1'b0;
  logic                     core_seq_d_err = 1'b0;
  logic                     seq_core_pat_vld;
  logic [3:0]               seq_core_pat_idx;
  logic [PAT_W-1:0]         seq_core_pat_data;
  logic                     seq_core_port_sel;
  logic                     seq_core_go;
  logic                     seq_busy;
  logic                     seq_done;
  logic [3:0]               seq_err_status;
  logic                     seq_timeout;

  core_test_seq #(.TIMEOUT_CYC(TMO)) dut (
    .clk_50m           (clk_50m),
    .rst_core_n        (rst_core_n),
    .test_start        (test_start),
    .test_abort        (test_abort),
    .port_mask         (port_mask),
    .pattern_bus       (pattern_bus),
    .seq_core_pat_vld  (seq_core_pat_vld),
    .seq_core_pat_idx  (seq_core_pat_idx),
    .seq_core_pat_data (seq_core_pat_data),
    .core_seq_pat_rdy  (core_seq_pat_rdy),
    .seq_core_port_sel (seq_core_port_sel),
    .seq_core_go       (seq_core_go),
    .core_seq_busy     (core_seq_busy),
    .core_seq_end      (core_seq_end),
    .core_seq_a_err    (core_seq_a_err),
    .core_seq_d_err    (core_seq_d_err),
    .seq_busy          (seq_busy),
    .seq_done          (seq_done),
    .seq_err_status    (seq_err_status),
    .seq_timeout       (seq_timeout)
  );

  always #10 clk_50m = ~clk_50m;

  int cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  // Core responder: rdy pattern, busy/end handshake and optional error pulses.
  int         rdy_mode = 0;
  logic [1:0] inj_a = 2'b00;
  logic [1:0] inj_d = 2'b00;
  bit         never_busy = 1'b0;
  bit         act = 1'b0;
  int         tcnt = 0;
  logic       act_port = 1'b0;

  always @(posedge clk_50m) begin
    #1;
    case (rdy_mode)
      0:       core_seq_pat_rdy = 1'b1;
      1:       core_seq_pat_rdy = ~core_seq_pat_rdy;
      default: core_seq_pat_rdy = 1'($urandom_range(0, 1));
    endcase
    core_seq_a_err = 1'b0;
    core_seq_d_err = 1'b0;
    if (seq_core_go) begin
      act = 1'b1;
      tcnt = 0;
      act_port = seq_core_port_sel;
    end else if (act) begin
      tcnt++;
      if (tcnt == 2 && inj_d[act_port]) core_seq_d_err = 1'b1;
      if (tcnt == BUSY_DLY && !never_busy) core_seq_busy = 1'b1;
      if (tcnt == BUSY_DLY + 10 && inj_a[act_port]) core_seq_a_err = 1'b1;
      if (tcnt == BUSY_DLY + END_DLY && !never_busy) begin
        core_seq_busy = 1'b0;
        core_seq_end = 1'b1;
      end
      if (tcnt == BUSY_DLY + END_DLY + 3) begin
        core_seq_end = 1'b0;
        act = 1'b0;
      end
    end
  end

  // Observed transfers, pulses and stall stability.
  logic [28:0]      xq[$];
  int               cq[$];
  int               go_cnt = 0, done_cnt = 0, go_cyc = 0, done_cyc = 0, stall_bad = 0;
  bit               prev_stall = 1'b0;
  logic [3:0]       prev_idx = '0;
  logic [PAT_W-1:0] prev_data = '0;

  always @(negedge clk_50m) begin
    if (prev_stall && (!seq_core_pat_vld || seq_core_pat_idx !== prev_idx ||
                       seq_core_pat_data !== prev_data))
      stall_bad++;
    prev_stall = seq_core_pat_vld && !core_seq_pat_rdy;
    prev_idx   = seq_core_pat_idx;
    prev_data  = seq_core_pat_data;
    if (seq_core_pat_vld && core_seq_pat_rdy) begin
      xq.push_back({seq_core_port_sel, seq_core_pat_idx, seq_core_pat_data});
      cq.push_back(cyc);
    end
    if (seq_core_go) begin go_cnt++; go_cyc = cyc; end
    if (seq_done) begin done_cnt++; done_cyc = cyc; end
  end

  int n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [PAT_W-1:0] pat[NUM_PAT];

  task automatic set_patterns(input bit counting);
    for (int i = 0; i < NUM_PAT; i++) begin
      logic [3:0] d;
      d = 4'(i);
      pat[i] = counting ? {4'h0, d, 4'h0, d, 4'h0, d} : PAT_W'($urandom);
      pattern_bus[i*PAT_W +: PAT_W] = pat[i];
    end
  endtask

  task automatic clear_logs();
    xq.delete(); cq.delete();
    go_cnt = 0; done_cnt = 0; stall_bad = 0; prev_stall = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] m);
    port_mask = m;
    test_start = 1'b1;
    @(negedge clk_50m);
    test_start = 1'b0;
  endtask

  task automatic run(input logic [1:0] m, input int rmode, input logic [1:0] ia,
                     input logic [1:0] id, input bit nb, input bit restart, input string tag);
    bit          seen;
    logic [28:0] eq[$];
    logic [3:0]  e_err;
    int          e_go, bad, last_p;
    rdy_mode = rmode; inj_a = ia; inj_d = id; never_busy = nb;
    clear_logs();
    pulse_start(m);
    chk({tag, "_err_cleared"}, {seq_timeout, seq_err_status}, 5'd0);
    chk({tag, "_busy_after_start"}, seq_busy, 1'b1);
    if (restart) begin
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin @(negedge clk_50m); seen = seq_core_go; end
      chk({tag, "_go_seen"}, seen, 1'b1);
      repeat (3) @(negedge clk_50m);
      pulse_start(2'b11);
    end
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin @(negedge clk_50m); seen = seq_done; end
    chk({tag, "_done_seen"}, seen, 1'b1);
    repeat (3) @(negedge clk_50m);

    e_err = '0; e_go = 0; last_p = 0;
    for (int p = 0; p < 2; p++) begin
      if (m[p] && !(nb && e_go > 0)) begin
        for (int i = 0; i < NUM_PAT; i++) eq.push_back({p[0], i[3:0], pat[i]});
        e_go++;
        last_p = p;
        if (ia[p]) e_err[p ? ERR_AB : ERR_AA] = 1'b1;
        if (id[p]) e_err[p ? ERR_DB : ERR_DA] = 1'b1;
      end
    end
    bad = 0;
    for (int i = 0; i < eq.size() && i < xq.size(); i++) if (xq[i] !== eq[i]) bad++;
    chk({tag, "_xfer_count"}, xq.size(), eq.size());
    chk({tag, "_xfer_content"}, bad, 0);
    chk({tag, "_go_count"}, go_cnt, e_go);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_err_status"}, seq_err_status, e_err);
    chk({tag, "_timeout"}, seq_timeout, nb);
    chk({tag, "_stall_stable"}, stall_bad, 0);
    chk({tag, "_idle_after"}, seq_busy, 1'b0);
    chk({tag, "_port_sel_hold"}, seq_core_port_sel, last_p[0]);
    if (rmode == 0 && xq.size() == eq.size()) begin
      bad = 0;
      for (int k = 0; k < e_go; k++) if (cq[16*k+15] - cq[16*k] != 15) bad++;
      chk({tag, "_back_to_back"}, bad, 0);
    end
    if (nb) chk({tag, "_go_to_done"}, done_cyc - go_cyc, TMO);
    $display("run %s mask=%b rdy_mode=%0d xfers=%0d go=%0d err=%b timeout=%b",
             tag, m, rmode, xq.size(), go_cnt, seq_err_status, seq_timeout);
  endtask

  initial begin
    bit seen;
    #5 rst_core_n = 1'b0;
    repeat (3) @(negedge clk_50m);
    chk("reset_outputs", {seq_core_pat_vld, seq_core_pat_idx, seq_core_pat_data, seq_core_port_sel,
        seq_core_go, seq_busy, seq_done, seq_err_status, seq_timeout}, 38'd0);
    rst_core_n = 1'b1;
    repeat (2) @(negedge clk_50m);

    set_patterns(1'b1);
    run(2'b01, 0, 2'b00, 2'b00, 1'b0, 1'b0, "t1_port_a");
    set_patterns(1'b0);
    run(2'b11, 1, 2'b00, 2'b00, 1'b0, 1'b0, "t2_backpressure");
    run(2'b11, 0, 2'b01, 2'b10, 1'b0, 1'b0, "t3_errors");
    run(2'b01, 0, 2'b00, 2'b00, 1'b0, 1'b1, "t5_restart_ignored");
    run(2'b11, 0, 2'b00, 2'b00, 1'b1, 1'b0, "t4_timeout");
    run(2'b10, 2, 2'b10, 2'b00, 1'b0, 1'b0, "t2_port_b_only");

    // Abort during LOAD at index 7.
    rdy_mode = 0; never_busy = 1'b0; inj_a = '0; inj_d = '0;
    clear_logs();
    pulse_start(2'b11);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      seen = seq_core_pat_vld && (seq_core_pat_idx == 4'd7);
      if (!seen) @(negedge clk_50m);
    end
    chk("abort_idx7_reached", seen, 1'b1);
    test_abort = 1'b1;
    @(negedge clk_50m);
    test_abort = 1'b0;
    chk("abort_vld_drop", seq_core_pat_vld, 1'b0);
    chk("abort_done_pulse", seq_done, 1'b1);
    @(negedge clk_50m);
    chk("abort_idle", seq_busy, 1'b0);
    repeat (40) @(negedge clk_50m);
    chk("abort_no_go", go_cnt, 0);
    chk("abort_done_once", done_cnt, 1);
    $display("run abort mask=11 xfers=%0d go=%0d", xq.size(), go_cnt);

    // Abort while idle does nothing.
    test_abort = 1'b1;
    @(negedge clk_50m);
    test_abort = 1'b0;
    chk("idle_abort_no_done", {seq_done, seq_busy}, 2'b00);

    // Asynchronous reset while waiting for the end of a port B test.
    clear_logs();
    pulse_start(2'b10);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk_50m); seen = core_seq_busy; end
    chk("rst_busy_seen", seen, 1'b1);
    repeat (6) @(negedge clk_50m);
    chk("pre_rst_state", {seq_busy, seq_core_port_sel}, 2'b11);
    rst_core_n = 1'b0;
    #1;
    chk("async_reset_outputs", {seq_core_pat_vld, seq_core_pat_idx, seq_core_pat_data,
        seq_core_port_sel, seq_core_go, seq_busy, seq_done, seq_err_status, seq_timeout}, 38'd0);
    repeat (40) @(negedge clk_50m);
    rst_core_n = 1'b1;
    repeat (2) @(negedge clk_50m);
    $display("run reset_mid_wait_end mask=10");

    // Empty mask: done pulse only.
    clear_logs();
    pulse_start(2'b00);
    chk("mask0_done", seq_done, 1'b1);
    chk("mask0_not_busy", seq_busy, 1'b0);
    @(negedge clk_50m);
    chk("mask0_done_single", seq_done, 1'b0);
    repeat (20) @(negedge clk_50m);
    chk("mask0_no_go", go_cnt, 0);
    chk("mask0_no_xfer", xq.size(), 0);
    $display("run mask0 done_cnt=%0d", done_cnt);

    for (int r = 0; r < 6; r++) begin
      logic [1:0] m, ia, id;
      int rm;
      m  = 2'($urandom_range(1, 3));
      ia = 2'($urandom_range(0, 3));
      id = 2'($urandom_range(0, 3));
      rm = int'($urandom_range(0, 2));
      set_patterns(1'b0);
      run(m, rm, ia, id, 1'b0, 1'b0, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
